// File: rtl/commit_queue.sv
// Commit queue: DEPTH-entry FIFO of retired-instruction records feeding the difftest outputs,
// with sticky trap detection and cycle/instruction counters. Optional: COMMIT_QUEUE_BYPASS_EN.
module commit_queue #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned DEPTH   = 4,
  parameter logic [6:0]  TRAP_OP = 7'h6b
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            in_wen,
  input  logic [4:0]      in_wdest,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [7:0]      in_code,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            out_wen,
  output logic [7:0]      out_wdest,
  output logic [XLEN-1:0] out_wdata,
  output logic            trap_valid,
  output logic [7:0]      trap_code,
  output logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] instr_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]  CNT_ONE = {{(XLEN-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            wen;
    logic [4:0]      wdest;
    logic [XLEN-1:0] wdata;
    logic [7:0]      code;
  } rec_t;

  rec_t            mem_q [DEPTH];
  rec_t            mem_d [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d, out_wdata_q, out_wdata_d;
  logic [31:0]     out_inst_q, out_inst_d;
  logic            out_wen_q, out_wen_d;
  logic [4:0]      out_wdest_q, out_wdest_d;
  logic            trap_valid_q, trap_valid_d;
  logic [7:0]      trap_code_q, trap_code_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d, cycle_cnt_q, cycle_cnt_d, instr_cnt_q, instr_cnt_d;

  rec_t in_rec, drain_rec;
  logic empty, full, push, pop, bypass, push_fifo, drain, is_trap;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready  = ~full & ~trap_valid_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_ready & ~empty & ~trap_valid_q;
`ifdef COMMIT_QUEUE_BYPASS_EN
  assign bypass    = empty & out_ready & ~trap_valid_q & push;
`else
  assign bypass    = 1'b0;
`endif
  assign push_fifo = push & ~bypass;
  assign drain     = pop | bypass;
  assign in_rec    = '{pc: in_pc, inst: in_inst, wen: in_wen, wdest: in_wdest,
                       wdata: in_wdata, code: in_code};
  assign drain_rec = bypass ? in_rec : mem_q[rd_ptr_q[AW-1:0]];
  assign is_trap   = drain & (drain_rec.inst[6:0] == TRAP_OP);

  // Storage write: only the slot under the write pointer changes.
  always_comb begin
    mem_d = mem_q;
    if (push_fifo) begin
      mem_d[wr_ptr_q[AW-1:0]] = in_rec;
    end else begin
      mem_d = mem_q;
    end
  end

  // Next-state for pointers, drained record, trap latch and counters.
  always_comb begin
    wr_ptr_d     = push_fifo ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d     = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    out_valid_d  = drain;
    out_pc_d     = out_pc_q;
    out_inst_d   = out_inst_q;
    out_wen_d    = out_wen_q;
    out_wdest_d  = out_wdest_q;
    out_wdata_d  = out_wdata_q;
    trap_valid_d = trap_valid_q;
    trap_code_d  = trap_code_q;
    trap_pc_d    = trap_pc_q;
    instr_cnt_d  = instr_cnt_q;
    if (drain) begin
      out_pc_d    = drain_rec.pc;
      out_inst_d  = drain_rec.inst;
      out_wen_d   = drain_rec.wen;
      out_wdest_d = drain_rec.wdest;
      out_wdata_d = drain_rec.wdata;
      instr_cnt_d = instr_cnt_q + CNT_ONE;
    end else begin
      instr_cnt_d = instr_cnt_q;
    end
    if (is_trap) begin
      trap_valid_d = 1'b1;
      trap_code_d  = drain_rec.code;
      trap_pc_d    = drain_rec.pc;
    end else begin
      trap_valid_d = trap_valid_q;
    end
    if (trap_valid_q) begin
      cycle_cnt_d = cycle_cnt_q;
    end else begin
      cycle_cnt_d = cycle_cnt_q + CNT_ONE;
    end
  end

  // Record storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_inst_q   <= 32'd0;
      out_wen_q    <= 1'b0;
      out_wdest_q  <= 5'd0;
      out_wdata_q  <= '0;
      trap_valid_q <= 1'b0;
      trap_code_q  <= 8'd0;
      trap_pc_q    <= '0;
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_inst_q   <= out_inst_d;
      out_wen_q    <= out_wen_d;
      out_wdest_q  <= out_wdest_d;
      out_wdata_q  <= out_wdata_d;
      trap_valid_q <= trap_valid_d;
      trap_code_q  <= trap_code_d;
      trap_pc_q    <= trap_pc_d;
      cycle_cnt_q  <= cycle_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pc     = out_pc_q;
  assign out_inst   = out_inst_q;
  assign out_wen    = out_wen_q;
  assign out_wdest  = {3'd0, out_wdest_q};
  assign out_wdata  = out_wdata_q;
  assign trap_valid = trap_valid_q;
  assign trap_code  = trap_code_q;
  assign trap_pc    = trap_pc_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign instr_cnt  = instr_cnt_q;

endmodule

// File: tb/tb_commit_queue.sv
// Bench for commit_queue: directed scenarios plus random traffic checked against a queue model.
module tb_commit_queue;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 4;
`ifdef COMMIT_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  wdest;
    logic [63:0] wdata;
    logic [7:0]  code;
  } rec_t;

  logic clock = 1'b0;
  logic reset, in_valid, in_ready, in_wen, out_ready, out_valid, out_wen, trap_valid;
  logic [63:0] in_pc, in_wdata, out_pc, out_wdata, trap_pc, cycle_cnt, instr_cnt;
  logic [31:0] in_inst, out_inst;
  logic [4:0]  in_wdest;
  logic [7:0]  in_code, out_wdest, trap_code;

  commit_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .TRAP_OP(7'h6b)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_wen(in_wen), .in_wdest(in_wdest),
    .in_wdata(in_wdata), .in_code(in_code), .out_ready(out_ready), .out_valid(out_valid),
    .out_pc(out_pc), .out_inst(out_inst), .out_wen(out_wen), .out_wdest(out_wdest),
    .out_wdata(out_wdata), .trap_valid(trap_valid), .trap_code(trap_code), .trap_pc(trap_pc),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  rec_t        mq[$];
  logic        e_ov, e_wen, e_trap;
  logic [63:0] e_pc, e_wdata, e_tpc, e_cyc, e_icnt;
  logic [31:0] e_inst;
  logic [4:0]  e_wdest;
  logic [7:0]  e_tcode;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic rec_t mk(input logic [63:0] pc, input logic [31:0] inst, input logic [7:0] code);
    rec_t r;
    r.pc = pc; r.inst = inst; r.code = code;
    r.wen = inst[7:0] != 8'd0; r.wdest = inst[11:7]; r.wdata = pc ^ 64'h5a5a_0000_1234_0000;
    return r;
  endfunction

  function automatic rec_t rnd_rec();
    rec_t r;
    r.pc = {$urandom, $urandom}; r.inst = $urandom;
    if (r.inst[6:0] == 7'h6b) r.inst[0] = ~r.inst[0];
    r.wen = 1'($urandom); r.wdest = 5'($urandom); r.wdata = {$urandom, $urandom};
    r.code = 8'($urandom);
    return r;
  endfunction

  function automatic void model_reset();
    mq.delete();
    e_ov = 1'b0; e_wen = 1'b0; e_trap = 1'b0; e_pc = 64'd0; e_wdata = 64'd0; e_tpc = 64'd0;
    e_cyc = 64'd0; e_icnt = 64'd0; e_inst = 32'd0; e_wdest = 5'd0; e_tcode = 8'd0;
  endfunction

  // One clock cycle: drive at negedge, advance model, compare just after posedge.
  task automatic cyc(input bit rst, input bit v, input bit rdy, input rec_t r);
    rec_t d;
    bit   have_d, push, exp_rdy;
    @(negedge clock);
    reset = rst; in_valid = v; out_ready = rdy;
    in_pc = r.pc; in_inst = r.inst; in_wen = r.wen; in_wdest = r.wdest;
    in_wdata = r.wdata; in_code = r.code;
    exp_rdy = (mq.size() < DEPTH) && !e_trap;
    #1;
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    if (rst) begin
      model_reset();
    end else begin
      push = v && exp_rdy;
      have_d = 1'b0;
      if (!e_trap && rdy) begin
        if (mq.size() > 0) begin
          d = mq.pop_front(); have_d = 1'b1;
        end else if (BYP && push) begin
          d = r; have_d = 1'b1; push = 1'b0;
        end
      end
      if (push) mq.push_back(r);
      if (!e_trap) e_cyc = e_cyc + 64'd1;
      e_ov = have_d;
      if (have_d) begin
        e_pc = d.pc; e_inst = d.inst; e_wen = d.wen; e_wdest = d.wdest; e_wdata = d.wdata;
        e_icnt = e_icnt + 64'd1;
        if (d.inst[6:0] == 7'h6b) begin
          e_trap = 1'b1; e_tcode = d.code; e_tpc = d.pc;
        end
      end
    end
    @(posedge clock);
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, e_ov});
    chk("out_pc", out_pc, e_pc);
    chk("out_inst", {32'd0, out_inst}, {32'd0, e_inst});
    chk("out_wen", {63'd0, out_wen}, {63'd0, e_wen});
    chk("out_wdest", {56'd0, out_wdest}, {59'd0, e_wdest});
    chk("out_wdata", out_wdata, e_wdata);
    chk("trap_valid", {63'd0, trap_valid}, {63'd0, e_trap});
    chk("trap_code", {56'd0, trap_code}, {56'd0, e_tcode});
    chk("trap_pc", trap_pc, e_tpc);
    chk("cycle_cnt", cycle_cnt, e_cyc);
    chk("instr_cnt", instr_cnt, e_icnt);
  endtask

  rec_t idle;
  rec_t t1;

  initial begin
    idle = mk(64'd0, 32'd0, 8'd0);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 64'd0; in_inst = 32'd0; in_wen = 1'b0; in_wdest = 5'd0; in_wdata = 64'd0; in_code = 8'd0;
    repeat (2) @(posedge clock);
    model_reset();
    cyc(1'b1, 1'b0, 1'b0, idle);
    chk("rst_cycle_cnt", cycle_cnt, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);

    // Single record through the queue
    t1 = mk(64'h8000_0000, 32'h0010_0093, 8'd0);
    t1.wen = 1'b1; t1.wdest = 5'd1; t1.wdata = 64'd1;
    cyc(1'b0, 1'b1, 1'b1, t1);
    if (BYP) chk("t1_bypass_valid", {63'd0, out_valid}, 64'd1);
    cyc(1'b0, 1'b0, 1'b1, idle);
    if (!BYP) chk("t1_fifo_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_wdest", {56'd0, out_wdest}, 64'd1);
    chk("t1_instr_cnt", instr_cnt, 64'd1);

    // Fill with sink stalled, attempt a fifth push, then drain
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, rnd_rec());
    chk("t2_full", {63'd0, in_ready}, 64'd0);
    // Full plus simultaneous offer: pop only
    cyc(1'b0, 1'b1, 1'b1, rnd_rec());
    chk("t3_one_free", 64'(mq.size()), 64'(DEPTH - 1));
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, idle);

    // Reset with the queue half full
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b0, rnd_rec());
    cyc(1'b1, 1'b0, 1'b0, idle);
    chk("t5_instr_cnt", instr_cnt, 64'd0);
    chk("t5_in_ready", {63'd0, in_ready}, 64'd1);
    cyc(1'b0, 1'b0, 1'b1, idle);
    chk("t5_empty_no_valid", {63'd0, out_valid}, 64'd0);

    // Random fill/drain across several pointer wraps
    for (int i = 0; i < 600; i++) begin
      if (i == 300) cyc(1'b1, 1'b0, 1'b0, idle);
      else cyc(1'b0, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 5), rnd_rec());
    end

    // Trap scenario from a clean reset
    cyc(1'b1, 1'b0, 1'b0, idle);
    cyc(1'b0, 1'b1, 1'b1, mk(64'h8000_0100, 32'h0000_0013, 8'h11));
    cyc(1'b0, 1'b1, 1'b1, mk(64'h8000_0104, 32'h0000_006b, 8'h00));
    cyc(1'b0, 1'b1, 1'b1, mk(64'h8000_0108, 32'h0010_0093, 8'h22));
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1, rnd_rec());
    chk("t4_trap_valid", {63'd0, trap_valid}, 64'd1);
    chk("t4_trap_code", {56'd0, trap_code}, 64'd0);
    chk("t4_trap_pc", trap_pc, 64'h8000_0104);
    chk("t4_instr_cnt", instr_cnt, 64'd2);

    // Reset clears the trap and restarts traffic
    cyc(1'b1, 1'b0, 1'b0, idle);
    chk("post_trap_clear", {63'd0, trap_valid}, 64'd0);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'($urandom), 1'($urandom), rnd_rec());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
